// File: rtl/axi_mem_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axi_mem_arbiter_pkg;

  // Transaction FSM: one whole transaction in flight at a time.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRaddr = 3'd1,
    StRdata = 3'd2,
    StWaddr = 3'd3,
    StWresp = 3'd4
  } state_e;

  // AxPROT values the requesters are expected to drive.
  localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
  localparam logic [2:0] AXI_PROT_DATA  = 3'b000;

  // Round-robin pick for two requesters: 0 selects M0, 1 selects M1.
  // On a tie the requester that did not win last time is chosen.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    return (req0 & req1) ? ~last : req1;
  endfunction

endpackage

// File: rtl/axi_mem_arbiter_rr_arb2.sv
// Combinational two-request round-robin selector.
module axi_mem_arbiter_rr_arb2
  import axi_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic pick
);

  // Pick a winner whenever anyone is requesting.
  always_comb begin
    valid = req0 | req1;
    pick  = rr_pick(req0, req1, last);
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI4-Lite master port between an instruction-fetch reader (M0) and a
// data load/store port (M1). Whole transactions are granted round-robin, one at a time,
// with a per-phase watchdog that abandons a stuck transaction.
module axi_mem_arbiter
  import axi_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                clock,
  input  logic                resetn,
  // M0: instruction fetch, read only
  input  logic                m0_arvalid,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [2:0]          m0_arprot,
  output logic                m0_arready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m0_rready,
  // M1: data port, read and write
  input  logic                m1_arvalid,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [2:0]          m1_arprot,
  output logic                m1_arready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  input  logic                m1_rready,
  input  logic                m1_awvalid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [2:0]          m1_awprot,
  output logic                m1_awready,
  input  logic                m1_wvalid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_wready,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // Toward the external slave
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [2:0]          s_arprot,
  input  logic                s_arready,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                s_rready,
  output logic                s_awvalid,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [2:0]          s_awprot,
  input  logic                s_awready,
  output logic                s_wvalid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wready,
  input  logic                s_bvalid,
  output logic                s_bready,
  // Status
  output logic                grant,
  output logic                bus_err
);

  // Counter is kept at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int unsigned CntW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TimeoutLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutLast);
  localparam bit WdEn = (TIMEOUT > 0);

  state_e          state_q;
  logic            grant_q;
  logic            last_q;
  logic            aw_done_q;
  logic            w_done_q;
  logic [CntW-1:0] cnt_q;
  logic            bus_err_q;

  logic req0, req1, m1_wr_req;
  logic arb_valid, arb_pick;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic wd_expire;

  assign req0      = m0_arvalid;
  assign m1_wr_req = m1_awvalid & m1_wvalid;
  assign req1      = m1_arvalid | m1_wr_req;

  axi_mem_arbiter_rr_arb2 u_rr_arb2 (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .valid (arb_valid),
    .pick  (arb_pick)
  );

  assign ar_hs     = s_arvalid & s_arready;
  assign r_hs      = s_rvalid & s_rready;
  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;
  assign b_hs      = s_bvalid & s_bready;
  assign wd_expire = WdEn && (cnt_q == CntLast);

  assign grant   = grant_q;
  assign bus_err = bus_err_q;

  // Transaction FSM with write-phase flags and watchdog.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      if (WdEn && state_q != StIdle) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (arb_valid) begin
            grant_q <= arb_pick;
            // M1 with both a write and a read pending issues the write first.
            state_q <= (arb_pick && m1_wr_req) ? StWaddr : StRaddr;
          end
        end
        StRaddr: begin
          if (ar_hs) begin
            state_q <= StRdata;
            cnt_q   <= '0;
          end else if (wd_expire) begin
            state_q   <= StIdle;
            bus_err_q <= 1'b1;
            last_q    <= grant_q;
          end
        end
        StRdata: begin
          if (r_hs) begin
            state_q <= StIdle;
            last_q  <= grant_q;
          end else if (wd_expire) begin
            state_q   <= StIdle;
            bus_err_q <= 1'b1;
            last_q    <= grant_q;
          end
        end
        StWaddr: begin
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
            state_q   <= StWresp;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
          end else if (wd_expire) begin
            state_q   <= StIdle;
            bus_err_q <= 1'b1;
            last_q    <= grant_q;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
          end
        end
        StWresp: begin
          if (b_hs) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
          end else if (wd_expire) begin
            state_q   <= StIdle;
            bus_err_q <= 1'b1;
            last_q    <= grant_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Channel muxes: only the granted master is connected, and only in the matching phase.
  always_comb begin
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arprot   = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awprot   = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    unique case (state_q)
      StRaddr: begin
        if (grant_q) begin
          s_arvalid  = m1_arvalid;
          s_araddr   = m1_araddr;
          s_arprot   = m1_arprot;
          m1_arready = s_arready;
        end else begin
          s_arvalid  = m0_arvalid;
          s_araddr   = m0_araddr;
          s_arprot   = m0_arprot;
          m0_arready = s_arready;
        end
      end
      StRdata: begin
        if (grant_q) begin
          s_rready  = m1_rready;
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
        end else begin
          s_rready  = m0_rready;
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
        end
      end
      StWaddr: begin
        // A channel that already handshook is hidden from the slave until WRESP.
        s_awvalid  = m1_awvalid & ~aw_done_q;
        s_awaddr   = m1_awaddr;
        s_awprot   = m1_awprot;
        m1_awready = s_awready & ~aw_done_q;
        s_wvalid   = m1_wvalid & ~w_done_q;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        m1_wready  = s_wready & ~w_done_q;
      end
      StWresp: begin
        s_bready  = m1_bready;
        m1_bvalid = s_bvalid;
      end
      default: ;
    endcase
  end

endmodule
